dmem_arbiter: RTL and testbench

Two-port arbiter and sequencer for the shared single-port data memory in the MIPS datapath. The CPU load/store stage (port 0) and the program/data loader (port 1) both issue word accesses. The block picks one requester with round-robin priority and drives the memory for one cycle, then returns read data or a write acknowledge to the winner. Memory is synchronous: command sampled on one edge, read data valid the following cycle.

---
 rtl/dmem_arbiter.sv | 127 ++++++++++++
 tb/tb_dmem_arbiter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : dmem_arbiter
// Function : round-robin two-port sequencer for a shared synchronous data RAM
// Revision : 1.0
// ---------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              req0_i,
  input  logic              req1_i,
  input  logic              write0_i,
  input  logic              write1_i,
  input  logic [ADDR_W-1:0] address0_i,
  input  logic [ADDR_W-1:0] address1_i,
  input  logic [DATA_W-1:0] data_in0_i,
  input  logic [DATA_W-1:0] data_in1_i,
  output logic              grant0_o,
  output logic              grant1_o,
  output logic              valid0_o,
  output logic              valid1_o,
  output logic              err0_o,
  output logic              err1_o,
  output logic [DATA_W-1:0] data_out0_o,
  output logic [DATA_W-1:0] data_out1_o,
  output logic              mem_en_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_address_o,
  output logic [DATA_W-1:0] mem_data_in_o,
  input  logic [DATA_W-1:0] mem_data_out_i
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int AW1 = ADDR_W + 1;
  localparam logic [ADDR_W:0] DEPTH_C = AW1'(DEPTH);

  state_e              state_q;
  logic                last_grant_q;
  logic                cmd_port_q;
  logic                cmd_write_q;
  logic [ADDR_W-1:0]   cmd_addr_q;
  logic [DATA_W-1:0]   cmd_data_q;
  logic                cmd_oor_q;

  logic                win_d;
  logic                write_d;
  logic [ADDR_W-1:0]   addr_d;
  logic [DATA_W-1:0]   data_d;
  logic                oor_d;

  // On a tie the port that did not win last time takes the slot.
  always_comb begin
    win_d = 1'b0;
    if (req0_i && req1_i) begin
      win_d = ~last_grant_q;
    end else if (req1_i) begin
      win_d = 1'b1;
    end
    write_d = win_d ? write1_i   : write0_i;
    addr_d  = win_d ? address1_i : address0_i;
    data_d  = win_d ? data_in1_i : data_in0_i;
    oor_d   = ({1'b0, addr_d} >= DEPTH_C);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      cmd_port_q   <= 1'b0;
      cmd_write_q  <= 1'b0;
      cmd_addr_q   <= '0;
      cmd_data_q   <= '0;
      cmd_oor_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req0_i || req1_i) begin
            state_q      <= ISSUE;
            last_grant_q <= win_d;
            cmd_port_q   <= win_d;
            cmd_write_q  <= write_d;
            cmd_addr_q   <= addr_d;
            cmd_data_q   <= data_d;
            cmd_oor_q    <= oor_d;
          end
        end
        ISSUE:   state_q <= DONE;
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Reset gates the strobes so an in-flight command never reaches the RAM.
  logic issue_act;
  logic done_act;
  logic rd_ok;

  assign issue_act = (state_q == ISSUE) && !reset_i;
  assign done_act  = (state_q == DONE)  && !reset_i;
  assign rd_ok     = done_act && !cmd_write_q && !cmd_oor_q;

  assign grant0_o      = issue_act && !cmd_port_q;
  assign grant1_o      = issue_act &&  cmd_port_q;
  assign mem_en_o      = issue_act && !cmd_oor_q;
  assign mem_write_o   = mem_en_o && cmd_write_q;
  assign mem_address_o = mem_en_o ? cmd_addr_q : '0;
  assign mem_data_in_o = mem_en_o ? cmd_data_q : '0;

  assign valid0_o    = done_act && !cmd_port_q;
  assign valid1_o    = done_act &&  cmd_port_q;
  assign err0_o      = valid0_o && cmd_oor_q;
  assign err1_o      = valid1_o && cmd_oor_q;
  assign data_out0_o = (rd_ok && !cmd_port_q) ? mem_data_out_i : '0;
  assign data_out1_o = (rd_ok &&  cmd_port_q) ? mem_data_out_i : '0;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// Scoreboard bench for dmem_arbiter with a behavioural synchronous RAM (DEPTH = 1000).
module tb_dmem_arbiter;

  typedef struct packed {
    logic        port;
    logic        wr;
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
  } txn_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  req = 2'b00;
  logic [1:0]  wr = 2'b00;
  logic [9:0]  addr_v [2];
  logic [31:0] din_v [2];

  logic        grant0, grant1, valid0, valid1, err0, err1;
  logic [31:0] dout0, dout1;
  logic        mem_en, mem_write;
  logic [9:0]  mem_address;
  logic [31:0] mem_din;
  logic [31:0] mem_rd = 32'd0;
  logic [31:0] mem [0:1023];

  logic [1:0]  grant_v, valid_v;
  assign grant_v = {grant1, grant0};
  assign valid_v = {valid1, valid0};

  int   checks = 0;
  int   errors = 0;
  bit   auto_drv = 1'b0;
  txn_t q0[$];
  txn_t q1[$];
  txn_t exp_q[$];
  txn_t vld_q[$];

  dmem_arbiter #(.ADDR_W(10), .DATA_W(32), .DEPTH(1000)) dut (
    .clk_i          (clk),
    .reset_i        (reset),
    .req0_i         (req[0]),
    .req1_i         (req[1]),
    .write0_i       (wr[0]),
    .write1_i       (wr[1]),
    .address0_i     (addr_v[0]),
    .address1_i     (addr_v[1]),
    .data_in0_i     (din_v[0]),
    .data_in1_i     (din_v[1]),
    .grant0_o       (grant0),
    .grant1_o       (grant1),
    .valid0_o       (valid0),
    .valid1_o       (valid1),
    .err0_o         (err0),
    .err1_o         (err1),
    .data_out0_o    (dout0),
    .data_out1_o    (dout1),
    .mem_en_o       (mem_en),
    .mem_write_o    (mem_write),
    .mem_address_o  (mem_address),
    .mem_data_in_o  (mem_din),
    .mem_data_out_i (mem_rd)
  );

  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
    addr_v[0] = 10'd0; addr_v[1] = 10'd0;
    din_v[0]  = 32'd0; din_v[1]  = 32'd0;
  end

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_write) mem[mem_address] <= mem_din;
      else           mem_rd <= mem[mem_address];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic issue(input logic p, input logic w, input logic [9:0] a,
                       input logic [31:0] wd, input logic [31:0] rd, input logic e);
    txn_t t;
    t = '{port: p, wr: w, addr: a, wdata: wd, rdata: rd, err: e};
    if (p) q1.push_back(t);
    else   q0.push_back(t);
    exp_q.push_back(t);
  endtask

  task automatic drive_port(input bit p);
    txn_t t;
    forever begin
      @(negedge clk);
      if (auto_drv) begin
        if (grant_v[p]) begin
          if (p) q1.delete(0);
          else   q0.delete(0);
        end
        if ((p ? q1.size() : q0.size()) != 0) begin
          t = p ? q1[0] : q0[0];
          req[p] = 1'b1; wr[p] = t.wr; addr_v[p] = t.addr; din_v[p] = t.wdata;
        end else begin
          req[p] = 1'b0;
        end
      end
    end
  endtask

  initial drive_port(1'b0);
  initial drive_port(1'b1);

  initial begin : monitor
    txn_t t;
    logic pend;
    logic pend_port;
    pend = 1'b0;
    pend_port = 1'b0;
    forever begin
      @(negedge clk);
      if (pend) check("valid_latency", 32'(valid_v), pend_port ? 32'd2 : 32'd1);
      pend = 1'b0;
      if (grant_v != 2'b00) begin
        if (exp_q.size() == 0) begin
          check("unexpected_grant", 32'(grant_v), 32'd0);
        end else begin
          t = exp_q.pop_front();
          check("grant_port",  32'(grant_v), t.port ? 32'd2 : 32'd1);
          check("mem_en",      32'(mem_en), 32'(!t.err));
          check("mem_write",   32'(mem_write), 32'(!t.err && t.wr));
          check("mem_address", 32'(mem_address), t.err ? 32'd0 : 32'(t.addr));
          check("mem_data_in", mem_din, t.err ? 32'd0 : t.wdata);
          vld_q.push_back(t);
          pend = 1'b1;
          pend_port = t.port;
        end
      end else if (mem_en) begin
        check("stray_mem_en", 32'(mem_en), 32'd0);
      end
      if (valid_v != 2'b00) begin
        if (vld_q.size() == 0) begin
          check("unexpected_valid", 32'(valid_v), 32'd0);
        end else begin
          t = vld_q.pop_front();
          check("valid_port",     32'(valid_v), t.port ? 32'd2 : 32'd1);
          check("err",            32'(t.port ? err1 : err0), 32'(t.err));
          check("data_out",       t.port ? dout1 : dout0, t.rdata);
          check("other_data_out", t.port ? dout0 : dout1, 32'd0);
        end
      end
    end
  end

  task automatic drain();
    int n;
    n = 0;
    while ((q0.size() + q1.size() + exp_q.size() + vld_q.size()) != 0 && n < 60) begin
      @(posedge clk); #2;
      n++;
    end
    check("drain_timeout", 32'(n < 60), 32'd1);
    if (n >= 60) begin
      q0.delete(); q1.delete(); exp_q.delete(); vld_q.delete();
    end
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin : main
    // Reset held two cycles with a pending port-0 read.
    req[0] = 1'b1; wr[0] = 1'b0; addr_v[0] = 10'd0; din_v[0] = 32'd0;
    exp_q.push_back('{port: 1'b0, wr: 1'b0, addr: 10'd0, wdata: 32'd0, rdata: 32'd0, err: 1'b0});
    repeat (2) begin
      @(negedge clk);
      check("reset_outputs", 32'(|{grant_v, valid_v, err0, err1, mem_en, mem_write,
                                   mem_address, mem_din, dout0, dout1}), 32'd0);
    end
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("grant_after_reset", 32'(grant0), 32'd1);
    req[0] = 1'b0;
    drain();
    auto_drv = 1'b1;

    // Back-to-back write then read on port 0.
    issue(1'b0, 1'b1, 10'd5, 32'hDEADBEEF, 32'd0, 1'b0);
    issue(1'b0, 1'b0, 10'd5, 32'd0, 32'hDEADBEEF, 1'b0);
    drain();

    // Last in-range word, then two out-of-range reads from port 1.
    issue(1'b0, 1'b1, 10'd999, 32'hA5A5A5A5, 32'd0, 1'b0);
    drain();
    issue(1'b1, 1'b0, 10'd1000, 32'd0, 32'd0, 1'b1);
    issue(1'b1, 1'b0, 10'd1023, 32'd0, 32'd0, 1'b1);
    drain();

    // Port 1 won last, so sustained contention alternates starting with port 0.
    issue(1'b0, 1'b1, 10'd10, 32'h11111111, 32'd0, 1'b0);
    issue(1'b1, 1'b1, 10'd11, 32'h22222222, 32'd0, 1'b0);
    issue(1'b0, 1'b0, 10'd11, 32'd0, 32'h22222222, 1'b0);
    issue(1'b1, 1'b0, 10'd999, 32'd0, 32'hA5A5A5A5, 1'b0);
    drain();

    issue(1'b0, 1'b1, 10'd7, 32'h77777777, 32'd0, 1'b0);
    drain();

    // Reset lands in the ISSUE cycle of an overwrite of address 7.
    auto_drv = 1'b0;
    req[0] = 1'b1; wr[0] = 1'b1; addr_v[0] = 10'd7; din_v[0] = 32'hBAD0BAD0;
    @(posedge clk); #1;
    reset = 1'b1;
    req[0] = 1'b0;
    @(negedge clk);
    check("reset_issue_grant",  32'(grant_v), 32'd0);
    check("reset_issue_mem_en", 32'(mem_en), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("no_valid_after_reset", 32'(valid_v), 32'd0);
    end
    auto_drv = 1'b1;
    issue(1'b0, 1'b0, 10'd7, 32'd0, 32'h77777777, 1'b0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
